// File: rtl/simon_seq_gen.sv
// Replayable pseudo-random one-hot symbol sequence for the Simon game core.
// Optional build macro SEQ_GEN_FREERUN_EN: the seed LFSR free-runs and randomize is ignored.
module simon_seq_gen #(
  parameter int          NUM_SYMBOLS = 4,
  parameter int          LFSR_W      = 16,
  parameter logic [31:0] SEED_INIT   = 32'hACE1,
  parameter int          MAX_LEN     = 32,
  localparam int         SYM_W       = $clog2(NUM_SYMBOLS),
  localparam int         LEN_W       = $clog2(MAX_LEN)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_randomize,
  input  logic                   i_start_over,
  input  logic                   i_next,
  output logic [NUM_SYMBOLS-1:0] o_seq,
  output logic [LEN_W-1:0]       o_index,
  output logic                   o_last
);

  localparam logic [31:0] TAPS32 = (LFSR_W == 8)  ? 32'h0000_00B8 :
                                   (LFSR_W == 16) ? 32'h0000_B400 :
                                                    32'h8020_0003;
  localparam logic [LFSR_W-1:0] TAPS = TAPS32[LFSR_W-1:0];
  localparam logic [LFSR_W-1:0] SEED = SEED_INIT[LFSR_W-1:0];
  localparam logic [LEN_W-1:0]  LAST_IDX = LEN_W'(MAX_LEN - 1);

  generate
    if (LFSR_W != 8 && LFSR_W != 16 && LFSR_W != 32) begin : g_bad_lfsr_w
      $error("simon_seq_gen: LFSR_W must be 8, 16 or 32");
    end
    if (NUM_SYMBOLS < 2 || NUM_SYMBOLS > 16 ||
        (NUM_SYMBOLS & (NUM_SYMBOLS - 1)) != 0) begin : g_bad_num_symbols
      $error("simon_seq_gen: NUM_SYMBOLS must be a power of two in 2..16");
    end
    if (SEED_INIT[LFSR_W-1:0] == '0) begin : g_bad_seed
      $error("simon_seq_gen: SEED_INIT truncated to LFSR_W must be nonzero");
    end
    if (MAX_LEN < 2) begin : g_bad_max_len
      $error("simon_seq_gen: MAX_LEN must be at least 2");
    end
  endgenerate

  // Galois right-shift step; a nonzero state never maps to zero.
  function automatic logic [LFSR_W-1:0] f_lfsr_step(input logic [LFSR_W-1:0] x);
    return x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
  endfunction

  logic [LFSR_W-1:0] r_seed;
  logic [LFSR_W-1:0] r_play;
  logic [LEN_W-1:0]  r_idx;
  logic              w_seed_step;
  logic              w_last;

`ifdef SEQ_GEN_FREERUN_EN
  assign w_seed_step = 1'b1;
  logic w_unused_randomize;
  assign w_unused_randomize = i_randomize;
`else
  assign w_seed_step = i_randomize;
`endif

  assign w_last = (r_idx == LAST_IDX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_seed <= SEED;
    end else if (w_seed_step) begin
      r_seed <= f_lfsr_step(r_seed);
    end
  end

  // start_over samples the seed as it was before any same-edge randomize step.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_play <= SEED;
      r_idx  <= '0;
    end else if (i_start_over) begin
      r_play <= r_seed;
      r_idx  <= '0;
    end else if (i_next && !w_last) begin
      r_play <= f_lfsr_step(r_play);
      r_idx  <= r_idx + LEN_W'(1);
    end
  end

  always_comb begin
    o_seq = '0;
    o_seq[r_play[SYM_W-1:0]] = 1'b1;
  end

  assign o_index = r_idx;
  assign o_last  = w_last;

endmodule

// File: tb/tb_simon_seq_gen.sv
// Directed self-checking bench for simon_seq_gen (default and MAX_LEN=4 instances).
module tb_simon_seq_gen;

  logic       clk;
  logic       rst_n;
  logic       randomize_a, start_over_a, next_a;
  logic [3:0] seq_a;
  logic [4:0] index_a;
  logic       last_a;
  logic       randomize_b, start_over_b, next_b;
  logic [3:0] seq_b;
  logic [1:0] index_b;
  logic       last_b;

  int n_checks;
  int n_fail;

  logic [15:0] seed_m;
  logic [15:0] seed_old;
  logic [15:0] play_m;
  logic [3:0]  rec_seq [10];
  logic [4:0]  rec_idx [10];
  logic [3:0]  exp_seq [10];

  simon_seq_gen dut_a (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_randomize  (randomize_a),
    .i_start_over (start_over_a),
    .i_next       (next_a),
    .o_seq        (seq_a),
    .o_index      (index_a),
    .o_last       (last_a)
  );

  simon_seq_gen #(.MAX_LEN(4)) dut_b (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_randomize  (randomize_b),
    .i_start_over (start_over_b),
    .i_next       (next_b),
    .o_seq        (seq_b),
    .o_index      (index_b),
    .o_last       (last_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] f_step16(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  function automatic logic [3:0] f_oh(input logic [1:0] s);
    return 4'b0001 << s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    randomize_a = 0; start_over_a = 0; next_a = 0;
    randomize_b = 0; start_over_b = 0; next_b = 0;
    repeat (2) tick();
    n_checks++;
    if (seq_a !== 4'b0010) begin n_fail++; $display("FAIL reset_seq: got %b expected 0010", seq_a); end
    n_checks++;
    if (index_a !== 5'd0) begin n_fail++; $display("FAIL reset_index: got %0d expected 0", index_a); end
    n_checks++;
    if (last_a !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b expected 0", last_a); end
    n_checks++;
    if (seq_b !== 4'b0010 || index_b !== 2'd0 || last_b !== 1'b0) begin
      n_fail++; $display("FAIL reset_b: got seq=%b idx=%0d last=%b expected 0010/0/0", seq_b, index_b, last_b);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_next();
    next_a = 1; tick(); next_a = 0;
    n_checks++;
    if (seq_a !== 4'b0001 || index_a !== 5'd1) begin
      n_fail++; $display("FAIL next_first: got seq=%b idx=%0d expected 0001/1", seq_a, index_a);
    end
    tick();
    n_checks++;
    if (seq_a !== 4'b0001 || index_a !== 5'd1) begin
      n_fail++; $display("FAIL next_hold: got seq=%b idx=%0d expected 0001/1", seq_a, index_a);
    end
    next_a = 1; tick(); next_a = 0;
    n_checks++;
    if (seq_a !== 4'b0001 || index_a !== 5'd2) begin
      n_fail++; $display("FAIL next_second: got seq=%b idx=%0d expected 0001/2", seq_a, index_a);
    end
    next_a = 1;
    for (int k = 3; k <= 7; k++) begin
      tick();
      n_checks++;
      if (seq_a !== exp_seq[k] || index_a !== 5'(k) || last_a !== 1'b0) begin
        n_fail++;
        $display("FAIL next_held k=%0d: got seq=%b idx=%0d last=%b expected %b/%0d/0",
                 k, seq_a, index_a, last_a, exp_seq[k], k);
      end
    end
    next_a = 0;
  endtask

  task automatic test_async_reset();
    randomize_a = 1; repeat (3) tick(); randomize_a = 0;
    n_checks++;
    if (seq_a !== 4'b0010 || index_a !== 5'd7) begin
      n_fail++; $display("FAIL randomize_isolated: got seq=%b idx=%0d expected 0010/7", seq_a, index_a);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (seq_a !== 4'b0010 || index_a !== 5'd0 || last_a !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got seq=%b idx=%0d last=%b expected 0010/0/0", seq_a, index_a, last_a);
    end
    tick();
    rst_n = 1'b1;
    tick();
    start_over_a = 1; tick(); start_over_a = 0;
    next_a = 1; tick(); next_a = 0;
`ifndef SEQ_GEN_FREERUN_EN
    n_checks++;
    if (seq_a !== 4'b0001 || index_a !== 5'd1) begin
      n_fail++; $display("FAIL seed_lost: got seq=%b idx=%0d expected 0001/1", seq_a, index_a);
    end
`endif
  endtask

  task automatic test_randomize_replay();
    randomize_a = 1; repeat (37) tick(); randomize_a = 0;
    seed_m = 16'hACE1;
    for (int k = 0; k < 37; k++) seed_m = f_step16(seed_m);
    start_over_a = 1; tick(); start_over_a = 0;
    play_m = seed_m;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin next_a = 1; tick(); next_a = 0; end
      rec_seq[k] = seq_a;
      rec_idx[k] = index_a;
`ifndef SEQ_GEN_FREERUN_EN
      n_checks++;
      if (seq_a !== f_oh(play_m[1:0]) || index_a !== 5'(k)) begin
        n_fail++;
        $display("FAIL random_trace k=%0d: got seq=%b idx=%0d expected %b/%0d", k, seq_a, index_a, f_oh(play_m[1:0]), k);
      end
`endif
      play_m = f_step16(play_m);
    end
`ifndef SEQ_GEN_FREERUN_EN
    start_over_a = 1; tick(); start_over_a = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin next_a = 1; tick(); next_a = 0; end
      n_checks++;
      if (seq_a !== rec_seq[k] || index_a !== rec_idx[k]) begin
        n_fail++;
        $display("FAIL replay k=%0d: got seq=%b idx=%0d expected %b/%0d", k, seq_a, index_a, rec_seq[k], rec_idx[k]);
      end
    end
`else
    randomize_a = 0; repeat (20) tick();
    start_over_a = 1; tick(); start_over_a = 0;
    begin
      int diff = 0;
      play_m = 16'hACE1;
      for (int k = 0; k < 10; k++) begin
        if (k > 0) begin next_a = 1; tick(); next_a = 0; end
        if (seq_a !== f_oh(play_m[1:0])) diff++;
        play_m = f_step16(play_m);
      end
      n_checks++;
      if (diff == 0) begin n_fail++; $display("FAIL freerun: got reset-seed trace expected a different one"); end
    end
`endif
  endtask

  task automatic test_start_over_priority();
    start_over_a = 1; tick(); start_over_a = 0;
    next_a = 1; repeat (5) tick(); next_a = 0;
    n_checks++;
    if (index_a !== 5'd5) begin n_fail++; $display("FAIL prio_setup: got idx=%0d expected 5", index_a); end
    start_over_a = 1; next_a = 1; randomize_a = 1;
    tick();
    start_over_a = 0; next_a = 0; randomize_a = 0;
    seed_old = seed_m;
    seed_m = f_step16(seed_m);
    n_checks++;
    if (index_a !== 5'd0) begin n_fail++; $display("FAIL prio_index: got %0d expected 0", index_a); end
`ifndef SEQ_GEN_FREERUN_EN
    n_checks++;
    if (seq_a !== f_oh(seed_old[1:0])) begin
      n_fail++; $display("FAIL prio_seq: got %b expected %b", seq_a, f_oh(seed_old[1:0]));
    end
`endif
    tick();
    next_a = 1; tick(); next_a = 0;
`ifndef SEQ_GEN_FREERUN_EN
    n_checks++;
    if (seq_a !== f_oh(f_step16(seed_old) >> 0 & 16'h3) || index_a !== 5'd1) begin
      n_fail++; $display("FAIL prio_no_step: got seq=%b idx=%0d expected %b/1", seq_a, index_a, f_oh(f_step16(seed_old) & 16'h3));
    end
    start_over_a = 1; tick(); start_over_a = 0;
    n_checks++;
    if (seq_a !== f_oh(seed_m[1:0]) || index_a !== 5'd0) begin
      n_fail++; $display("FAIL prio_seed_stepped: got seq=%b idx=%0d expected %b/0", seq_a, index_a, f_oh(seed_m[1:0]));
    end
`endif
  endtask

  task automatic test_saturation();
    logic [1:0] exp_idx [6];
    logic       exp_last [6];
    exp_idx  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    exp_last = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    next_b = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_checks++;
      if (index_b !== exp_idx[k] || last_b !== exp_last[k] || seq_b !== 4'b0001) begin
        n_fail++;
        $display("FAIL saturate k=%0d: got idx=%0d last=%b seq=%b expected %0d/%b/0001",
                 k, index_b, last_b, seq_b, exp_idx[k], exp_last[k]);
      end
    end
    next_b = 0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_seq = '{4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0100,
                4'b1000, 4'b1000, 4'b0010, 4'b0001, 4'b0100};
    test_reset();
    test_next();
    test_async_reset();
    test_randomize_replay();
    test_start_over_priority();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
